// File: rtl/ovl_cycle_sequence_mc_pkg.sv
// Shared constants and helpers for the multi-channel cycle-sequence checker.
// Imported by the channel core and the aggregating top.
package ovl_cycle_seq_pkg;

    localparam int OVL_SEQ_TRIGGER_ON_MOST         = 0;
    localparam int OVL_SEQ_TRIGGER_ON_FIRST_PIPE   = 1;
    localparam int OVL_SEQ_TRIGGER_ON_FIRST_NOPIPE = 2;

    // Add that clamps to the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/ovl_cycle_sequence_mc_if.sv
// Sampling-side bundle of the cycle-sequence checker: event inputs,
// per-channel fire pulses and aggregate coverage counters.
interface ovl_cycle_sequence_mc_if #(
    parameter int NUM_CKS = 3,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16
);
    logic                      enable;
    logic [NUM_CH*NUM_CKS-1:0] event_sequence;
    logic [NUM_CH-1:0]         fire;
    logic                      fire_any;
    logic [CNT_W-1:0]          seq_started;
    logic [CNT_W-1:0]          seq_completed;
    logic [CNT_W-1:0]          fire_count;

    modport master (
        output enable, event_sequence,
        input  fire, fire_any,
        input  seq_started, seq_completed, fire_count
    );

    modport slave (
        input  enable, event_sequence,
        output fire, fire_any,
        output seq_started, seq_completed, fire_count
    );
endinterface

// File: rtl/ovl_cycle_sequence_mc_channel.sv
// One channel of the cycle-sequence checker: pending-attempt vector,
// registered fire and per-cycle start/done/fail strobes.
module ovl_cycle_seq_channel
    import ovl_cycle_seq_pkg::*;
#(
    parameter int NUM_CKS = 3,
    parameter int MODE    = OVL_SEQ_TRIGGER_ON_FIRST_PIPE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic [NUM_CKS-1:0] ev_i,
    output logic               fire_o,
    output logic               start_o,
    output logic               done_o,
    output logic               fail_o
);
    logic [NUM_CKS-1:1] pend_q;
    logic [NUM_CKS-1:1] pend_d;
    logic [NUM_CKS-1:1] miss;
    logic [NUM_CKS:1]   nxt;
    logic               fire_q;
    logic               start_d;
    logic               fail_d;

    // nxt[k] = attempt reaching stage k this cycle; nxt[NUM_CKS] = completion.
    always_comb begin
        nxt    = '0;
        miss   = '0;
        nxt[1] = ev_i[NUM_CKS-1];
        if (MODE == OVL_SEQ_TRIGGER_ON_FIRST_NOPIPE && (|pend_q))
            nxt[1] = 1'b0;
        for (int k = 1; k < NUM_CKS; k++) begin
            nxt[k+1] = pend_q[k] & ev_i[NUM_CKS-1-k];
            miss[k]  = pend_q[k] & ~ev_i[NUM_CKS-1-k];
        end
        // Trigger-on-most only checks the final step; earlier gaps drop silently.
        if (MODE == OVL_SEQ_TRIGGER_ON_MOST) begin
            start_d = nxt[NUM_CKS-1];
            fail_d  = miss[NUM_CKS-1];
        end else begin
            start_d = nxt[1];
            fail_d  = |miss;
        end
        pend_d  = en_i ? nxt[NUM_CKS-1:1] : '0;
        start_o = en_i & start_d;
        done_o  = en_i & nxt[NUM_CKS];
        fail_o  = en_i & fail_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            fire_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            fire_q <= fail_o;
        end
    end

    assign fire_o = fire_q;

endmodule

// File: rtl/ovl_cycle_sequence_mc.sv
// Multi-channel cycle-sequence checker: NUM_CH channel cores plus
// saturating popcount counters for starts, completions and fires.
module ovl_cycle_sequence_mc
    import ovl_cycle_seq_pkg::*;
#(
    parameter int NUM_CKS = 3,
    parameter int NUM_CH  = 4,
    parameter int MODE    = OVL_SEQ_TRIGGER_ON_FIRST_PIPE,
    parameter int CNT_W   = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    ovl_cycle_sequence_mc_if.slave bus
);
    if (NUM_CKS < 2 || NUM_CKS > 32) begin : g_bad_cks
        $error("NUM_CKS must be 2..32");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("NUM_CH must be 1..16");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("MODE must be 0..2");
    end
    if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt
        $error("CNT_W must be 1..63");
    end

    logic [NUM_CH-1:0] start_v;
    logic [NUM_CH-1:0] done_v;
    logic [NUM_CH-1:0] fail_v;
    logic [NUM_CH-1:0] fire_v;
    logic [CNT_W-1:0]  st_q, st_d;
    logic [CNT_W-1:0]  cm_q, cm_d;
    logic [CNT_W-1:0]  fc_q, fc_d;
    logic              fire_any_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ovl_cycle_seq_channel #(
            .NUM_CKS (NUM_CKS),
            .MODE    (MODE)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (bus.enable),
            .ev_i    (bus.event_sequence[c*NUM_CKS +: NUM_CKS]),
            .fire_o  (fire_v[c]),
            .start_o (start_v[c]),
            .done_o  (done_v[c]),
            .fail_o  (fail_v[c])
        );
    end

    always_comb begin
        st_d = CNT_W'(sat_add(64'(st_q), 64'($countones(start_v)), CNT_W));
        cm_d = CNT_W'(sat_add(64'(cm_q), 64'($countones(done_v)), CNT_W));
        fc_d = CNT_W'(sat_add(64'(fc_q), 64'($countones(fail_v)), CNT_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= '0;
            cm_q       <= '0;
            fc_q       <= '0;
            fire_any_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            cm_q       <= cm_d;
            fc_q       <= fc_d;
            fire_any_q <= |fail_v;
        end
    end

    assign bus.fire          = fire_v;
    assign bus.fire_any      = fire_any_q;
    assign bus.seq_started   = st_q;
    assign bus.seq_completed = cm_q;
    assign bus.fire_count    = fc_q;

endmodule

// File: tb/tb_ovl_cycle_sequence_mc.sv
// Scoreboard bench for ovl_cycle_sequence_mc: three instances, one per
// mode, share directed stimulus; expectations are queued per cycle.
module tb_ovl_cycle_sequence_mc;

    typedef struct {
        int          dut;
        bit          chk;
        logic [1:0]  f;
        logic        fa;
        logic [15:0] st;
        logic [15:0] cm;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    typedef struct packed {
        logic [1:0]  f;
        logic        fa;
        logic [15:0] st;
        logic [15:0] cm;
        logic [15:0] fc;
    } obs_t;

    logic clk;
    logic reset_n;
    int   nchk;
    int   nerr;
    exp_t sbq[$];
    exp_t mon_e;
    obs_t mon_o;

    ovl_cycle_sequence_mc_if #(.NUM_CKS(3), .NUM_CH(2), .CNT_W(16)) if0 ();
    ovl_cycle_sequence_mc_if #(.NUM_CKS(3), .NUM_CH(2), .CNT_W(16)) if1 ();
    ovl_cycle_sequence_mc_if #(.NUM_CKS(3), .NUM_CH(2), .CNT_W(16)) if2 ();

    ovl_cycle_sequence_mc #(
        .NUM_CKS(3), .NUM_CH(2), .MODE(0), .CNT_W(16)
    ) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    ovl_cycle_sequence_mc #(
        .NUM_CKS(3), .NUM_CH(2), .MODE(1), .CNT_W(16)
    ) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    ovl_cycle_sequence_mc #(
        .NUM_CKS(3), .NUM_CH(2), .MODE(2), .CNT_W(16)
    ) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic obs_t obs(int d);
        obs_t o;
        case (d)
            0: o = {if0.fire, if0.fire_any, if0.seq_started,
                    if0.seq_completed, if0.fire_count};
            1: o = {if1.fire, if1.fire_any, if1.seq_started,
                    if1.seq_completed, if1.fire_count};
            default: o = {if2.fire, if2.fire_any, if2.seq_started,
                          if2.seq_completed, if2.fire_count};
        endcase
        return o;
    endfunction

    // Monitor: one queued expectation per clock, compared on the falling edge.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            if (mon_e.chk) begin
                mon_o = obs(mon_e.dut);
                cmp({mon_e.nm, ".fire"}, 32'(mon_o.f), 32'(mon_e.f));
                cmp({mon_e.nm, ".fire_any"}, 32'(mon_o.fa), 32'(mon_e.fa));
                cmp({mon_e.nm, ".started"}, 32'(mon_o.st), 32'(mon_e.st));
                cmp({mon_e.nm, ".completed"}, 32'(mon_o.cm), 32'(mon_e.cm));
                cmp({mon_e.nm, ".fire_count"}, 32'(mon_o.fc), 32'(mon_e.fc));
            end
        end
    end

    task automatic drive(bit en, logic [5:0] ev);
        if0.enable = en;
        if1.enable = en;
        if2.enable = en;
        if0.event_sequence = ev;
        if1.event_sequence = ev;
        if2.event_sequence = ev;
    endtask

    task automatic step(int d, bit en, logic [5:0] ev, bit chk,
                        logic [1:0] f, logic fa, int st, int cm, int fc,
                        string nm);
        exp_t e;
        @(negedge clk);
        #1;
        drive(en, ev);
        e.dut = d;
        e.chk = chk;
        e.f   = f;
        e.fa  = fa;
        e.st  = 16'(st);
        e.cm  = 16'(cm);
        e.fc  = 16'(fc);
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    // Asynchronous reset pulse; optionally checks outputs while reset is low.
    task automatic rst(int d, bit chk_now, string nm);
        obs_t o;
        @(negedge clk);
        #1;
        drive(1'b1, 6'd0);
        reset_n = 1'b0;
        #1;
        if (chk_now) begin
            o = obs(d);
            cmp({nm, ".fire"}, 32'(o.f), 32'd0);
            cmp({nm, ".fire_any"}, 32'(o.fa), 32'd0);
            cmp({nm, ".started"}, 32'(o.st), 32'd0);
            cmp({nm, ".completed"}, 32'(o.cm), 32'd0);
            cmp({nm, ".fire_count"}, 32'(o.fc), 32'd0);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        nchk    = 0;
        nerr    = 0;
        reset_n = 1'b0;
        drive(1'b0, 6'd0);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;

        step(0, 1, 6'o00, 1, 2'b00, 0, 0, 0, 0, "rst_m0");
        step(1, 1, 6'o00, 1, 2'b00, 0, 0, 0, 0, "rst_m1");
        step(2, 1, 6'o00, 1, 2'b00, 0, 0, 0, 0, "rst_m2");

        // Mode 1 clean chain on ch0
        rst(1, 0, "");
        step(1, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 0, "m1ok_c0");
        step(1, 1, {3'b000, 3'b010}, 1, 2'b00, 0, 1, 0, 0, "m1ok_c1");
        step(1, 1, {3'b000, 3'b001}, 1, 2'b00, 0, 1, 1, 0, "m1ok_c2");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 1, 0, "m1ok_c3");

        // Mode 1 broken step 1 on ch0
        rst(1, 0, "");
        step(1, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 0, "m1bad_c0");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b01, 1, 1, 0, 1, "m1bad_c1");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 1, "m1bad_c2");

        // Overlapping start on ch1: mode 2 ignores it
        rst(2, 0, "");
        step(2, 1, {3'b100, 3'b000}, 1, 2'b00, 0, 1, 0, 0, "m2ov_c0");
        step(2, 1, {3'b110, 3'b000}, 1, 2'b00, 0, 1, 0, 0, "m2ov_c1");
        step(2, 1, {3'b001, 3'b000}, 1, 2'b00, 0, 1, 1, 0, "m2ov_c2");
        step(2, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 1, 0, "m2ov_c3");

        // Same stimulus in mode 1: second attempt fails
        rst(1, 0, "");
        step(1, 1, {3'b100, 3'b000}, 1, 2'b00, 0, 1, 0, 0, "m1ov_c0");
        step(1, 1, {3'b110, 3'b000}, 1, 2'b00, 0, 2, 0, 0, "m1ov_c1");
        step(1, 1, {3'b001, 3'b000}, 1, 2'b10, 1, 2, 1, 1, "m1ov_c2");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 2, 1, 1, "m1ov_c3");

        // Mode 0: qualified then missing last step; gap; clean chain
        rst(0, 0, "");
        step(0, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 0, 0, 0, "m0_c0");
        step(0, 1, {3'b000, 3'b010}, 1, 2'b00, 0, 1, 0, 0, "m0_c1");
        step(0, 1, {3'b000, 3'b000}, 1, 2'b01, 1, 1, 0, 1, "m0_c2");
        step(0, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 1, "m0_c3");
        step(0, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 1, "m0gap_c0");
        step(0, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 1, "m0gap_c1");
        step(0, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 1, "m0gap_c2");
        step(0, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 1, "m0ok_c0");
        step(0, 1, {3'b000, 3'b010}, 1, 2'b00, 0, 2, 0, 1, "m0ok_c1");
        step(0, 1, {3'b000, 3'b001}, 1, 2'b00, 0, 2, 1, 1, "m0ok_c2");

        // Mode 1: both channels fail together
        rst(1, 0, "");
        step(1, 1, {3'b100, 3'b100}, 1, 2'b00, 0, 2, 0, 0, "both_c0");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b11, 1, 2, 0, 2, "both_c1");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 2, 0, 2, "both_c2");

        // Reset in the middle of an attempt
        rst(1, 0, "");
        step(1, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 0, "mrst_c0");
        step(1, 1, {3'b000, 3'b010}, 1, 2'b00, 0, 1, 0, 0, "mrst_c1");
        rst(1, 1, "mrst_now");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 0, 0, 0, "mrst_c2");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 0, 0, 0, "mrst_c3");

        // Enable low flushes and blocks a start
        rst(1, 0, "");
        step(1, 1, {3'b000, 3'b100}, 1, 2'b00, 0, 1, 0, 0, "en_c0");
        step(1, 0, {3'b000, 3'b110}, 1, 2'b00, 0, 1, 0, 0, "en_c1");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 0, "en_c2");
        step(1, 1, {3'b000, 3'b000}, 1, 2'b00, 0, 1, 0, 0, "en_c3");

        // Long all-ones run: 2 starts/cycle, completions lag by 2 cycles
        rst(1, 0, "");
        for (int i = 0; i < 32766; i++)
            step(1, 1, 6'o77, 0, 2'b00, 0, 0, 0, 0, "");
        step(1, 1, 6'o77, 1, 2'b00, 0, 16'hFFFE, 16'hFFFA, 0, "sat_n1");
        step(1, 1, 6'o77, 1, 2'b00, 0, 16'hFFFF, 16'hFFFC, 0, "sat_n2");
        step(1, 1, 6'o77, 1, 2'b00, 0, 16'hFFFF, 16'hFFFE, 0, "sat_n3");
        step(1, 1, 6'o77, 1, 2'b00, 0, 16'hFFFF, 16'hFFFF, 0, "sat_n4");
        step(1, 1, 6'o77, 1, 2'b00, 0, 16'hFFFF, 16'hFFFF, 0, "sat_n5");

        for (int i = 0; i < 10 && sbq.size() != 0; i++)
            @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
